// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, EX redirect, instruction-memory handshake and IF/ID outputs.
// master = the fetch stage, slave = the surrounding pipeline / memory.
interface if_fetch_stage_if #(
   parameter int XLEN = 32
);
   logic            pc_write;
   logic            if_id_write;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_req_ready;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            if_id_valid;
   logic [XLEN-1:0] if_id_pc;
   logic [XLEN-1:0] if_id_inst;

   modport master (
      input  pc_write, if_id_write, redirect_valid, redirect_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output imem_req_valid, imem_req_addr,
      output if_id_valid, if_id_pc, if_id_inst
   );

   modport slave (
      output pc_write, if_id_write, redirect_valid, redirect_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  imem_req_valid, imem_req_addr,
      input  if_id_valid, if_id_pc, if_id_inst
   );
endinterface

// File: rtl/if_fetch_stage.sv
// RISC-V instruction fetch: PC, one-outstanding imem request, one-entry hold buffer, IF/ID register.
// Optional fetch/flush performance counters are enabled with IF_PERF_CNT_EN.
module if_fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   if_fetch_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic [XLEN-1:0] hold_inst_q, hold_inst_d;
   logic [XLEN-1:0] hold_pc_q, hold_pc_d;
   logic            ifid_vld_q, ifid_vld_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
   logic [XLEN-1:0] ifid_inst_q, ifid_inst_d;
   logic            req_vld;
   logic            deliver;
   logic [XLEN-1:0] dlv_pc, dlv_inst;

   assign req_vld            = (state_q == FETCH) && bus.pc_write && !bus.redirect_valid;
   assign bus.imem_req_valid = req_vld;
   assign bus.imem_req_addr  = pc_q;
   assign bus.if_id_valid    = ifid_vld_q;
   assign bus.if_id_pc       = ifid_pc_q;
   assign bus.if_id_inst     = ifid_inst_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      hold_inst_d = hold_inst_q;
      hold_pc_d   = hold_pc_q;
      ifid_vld_d  = ifid_vld_q;
      ifid_pc_d   = ifid_pc_q;
      ifid_inst_d = ifid_inst_q;
      deliver     = 1'b0;
      dlv_pc      = '0;
      dlv_inst    = NOP;

      case (state_q)
         FETCH: begin
            if (req_vld && bus.imem_req_ready) begin
               req_pc_d = pc_q;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (bus.imem_rsp_valid) begin
               pc_d = req_pc_q + XLEN'(4);
               if (bus.if_id_write) begin
                  deliver  = 1'b1;
                  dlv_pc   = req_pc_q;
                  dlv_inst = bus.imem_rsp_data;
                  state_d  = FETCH;
               end else begin
                  hold_pc_d   = req_pc_q;
                  hold_inst_d = bus.imem_rsp_data;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.if_id_write) begin
               deliver  = 1'b1;
               dlv_pc   = hold_pc_q;
               dlv_inst = hold_inst_q;
               state_d  = FETCH;
            end
         end
         DROP: begin
            if (bus.imem_rsp_valid) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      if (deliver) begin
         ifid_vld_d  = 1'b1;
         ifid_pc_d   = dlv_pc;
         ifid_inst_d = dlv_inst;
      end else if (bus.if_id_write) begin
         ifid_vld_d  = 1'b0;
         ifid_pc_d   = '0;
         ifid_inst_d = NOP;
      end

      // A redirect overrides everything above; an outstanding request must still be drained.
      if (bus.redirect_valid) begin
         deliver     = 1'b0;
         pc_d        = bus.redirect_pc;
         ifid_vld_d  = 1'b0;
         ifid_pc_d   = '0;
         ifid_inst_d = NOP;
         hold_pc_d   = '0;
         hold_inst_d = '0;
         if ((state_q == WAIT) || (state_q == DROP)) begin
            state_d = bus.imem_rsp_valid ? FETCH : DROP;
         end else begin
            state_d = FETCH;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         hold_inst_q <= '0;
         hold_pc_q   <= '0;
         ifid_vld_q  <= 1'b0;
         ifid_pc_q   <= '0;
         ifid_inst_q <= NOP;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         hold_inst_q <= hold_inst_d;
         hold_pc_q   <= hold_pc_d;
         ifid_vld_q  <= ifid_vld_d;
         ifid_pc_q   <= ifid_pc_d;
         ifid_inst_q <= ifid_inst_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_flush_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (deliver) perf_fetch_q <= perf_fetch_q + 32'd1;
         if (bus.redirect_valid) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage of the 5-stage RISC-V core. It owns the PC register, issues one-outstanding requests to instruction memory over a valid/ready handshake, and loads the IF/ID pipeline register. It consumes the `pc_write` / `if_id_write` stall controls from the hazard detection unit and the branch/jump redirect from EX. A one-entry hold buffer keeps a response that returns while ID is stalled.

## Interface
Parameters:
- `XLEN`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc_write` in 1: 0 = hold the PC and issue no new request (hazard stall).
- `if_id_write` in 1: 0 = hold the IF/ID register.
- `redirect_valid` in 1: taken branch/jump resolved in EX; flushes the front end.
- `redirect_pc` in XLEN: redirect target.
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out XLEN: fetch address, equal to the PC.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: instruction returned, in order, at least 1 cycle after acceptance.
- `imem_rsp_data` in XLEN: returned instruction.
- `if_id_valid` out 1: the IF/ID register holds a real instruction.
- `if_id_pc` out XLEN: PC of the IF/ID instruction.
- `if_id_inst` out XLEN: IF/ID instruction; 32'h0000_0013 (NOP) when invalid.

## Operation
- Registers:
  - `pc`: next request address.
  - `req_pc`: address of the in-flight request.
  - `hold_inst`, `hold_pc`: the one-entry hold buffer.
  - the IF/ID register: valid, pc, inst.
  - the FSM state.
- FSM states: FETCH, WAIT, HOLD, DROP.
- `imem_req_valid = (state==FETCH) && pc_write && !redirect_valid` (combinational). `imem_req_addr = pc`.
- FETCH:
  - On handshake (valid & ready): `req_pc <= pc`, then go to WAIT.
- WAIT, on `imem_rsp_valid`:
  - If `if_id_write`: IF/ID <= {1, req_pc, data}, `pc <= req_pc + 4`, go to FETCH.
  - Else: hold <= {req_pc, data}, `pc <= req_pc + 4`, go to HOLD.
- HOLD:
  - When `if_id_write`: IF/ID <= {1, hold_pc, hold_inst}, go to FETCH.
- DROP:
  - On `imem_rsp_valid`: discard the data, go to FETCH.
- Bubble rule: when `if_id_write=1` and no instruction is delivered this cycle, IF/ID <= {0, 0, NOP}.
- Redirect (`redirect_valid=1`) has the highest priority in every state:
  - `pc <= redirect_pc`.
  - IF/ID <= {0, 0, NOP}, regardless of `if_id_write`.
  - Hold buffer is discarded.
  - Next state: FETCH→FETCH, HOLD→FETCH, WAIT→DROP (or FETCH if `imem_rsp_valid` in the same cycle; that response is discarded), DROP→DROP (or FETCH if `imem_rsp_valid` in the same cycle).
- PC arithmetic is XLEN-bit modulo: 32'hFFFF_FFFC + 4 = 0. The low two bits pass through unmodified.
- `imem_rsp_valid` in FETCH or HOLD is a protocol violation and is ignored.

## Timing
- Reset values:
  - state FETCH, `pc = RESET_PC`, `req_pc = 0`, hold buffer = 0.
  - `if_id_valid = 0`, `if_id_pc = 0`, `if_id_inst = 32'h0000_0013`.
  - `imem_req_valid` is 1 once `rst` deasserts, provided `pc_write=1`.
- Best-case latency:
  - Request accepted in cycle N, response in N+1.
  - `if_id_valid=1` from N+2, and the next request issues in N+2.
  - Throughput is 1 instruction per 2 cycles with 1-cycle memory.
- Redirect in cycle N: IF/ID is invalid in N+1, and a request to `redirect_pc` issues in N+1 (or after the DROP response).
- Reset mid-request clears all state. Any response that arrives after reset deasserts, while the FSM is in FETCH, is ignored.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - Adds output `perf_fetch_cnt` (32 bits, reset 0).
  - The counter increments by 1 each cycle the IF/ID register is loaded with `if_id_valid=1` and wraps at 2^32.
  - Adds output `perf_flush_cnt` (32 bits, reset 0). It increments on each cycle with `redirect_valid=1`.
- Undefined: neither port nor its counters exists.

## Test plan
- Reset, then `RESET_PC=0`, 1-cycle memory, no stalls:
  - Requests go to 0, 4, 8 in cycles 0, 2, 4.
  - `if_id_pc` is 0, 4, 8 with `if_id_valid=1` in cycles 2, 4, 6.
- Response for 0x4 arrives with `if_id_write=0` for 3 cycles:
  - FSM sits in HOLD.
  - IF/ID keeps the prior instruction, and no request issues.
  - IF/ID loads 0x4 on the first `if_id_write=1` cycle.
- Redirect to 0x100 while in WAIT for 0x8:
  - The 0x8 response is dropped and `if_id_valid=0`.
  - The next request address is 0x100.
- Redirect in the same cycle as a response, and redirect with `pc_write=0` for 1 cycle:
  - The response is discarded.
  - `imem_req_valid=0` that cycle, and the following request goes to `redirect_pc`.
- `imem_req_ready=0` for 4 cycles at pc 0xC: `imem_req_addr` stays 0xC and `imem_req_valid` stays 1 throughout. Separately, pc 32'hFFFF_FFFC wraps to next address 0.
- With `IF_PERF_CNT_EN`:
  - 5 delivered instructions plus 2 redirects give `perf_fetch_cnt=5` and `perf_flush_cnt=2`.
  - `rst` mid-run clears both to 0.
